// File: rtl/scan_rate_controller.sv
// scan_rate_controller: locks onto motor revolution period and derives per-frame sample timing
// Optional watchdog: define SCAN_WATCHDOG_EN to fault when no index arrives within TIMEOUT cycles.
module scan_rate_controller #(
    parameter int CNT_W     = 26,
    parameter int RES_W     = 9,
    parameter int LOCK_REVS = 2,
    parameter int TOL_SHIFT = 4
`ifdef SCAN_WATCHDOG_EN
    , parameter int TIMEOUT = 50_000_000
`endif
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_req,
    input  logic [RES_W-1:0] res_cfg,
    input  logic             index_in,
    output logic [CNT_W-1:0] time_set,
    output logic [RES_W-1:0] resolution,
    output logic             sample_en,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] period,
    output logic             busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_MEAS  = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_LOCK  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int DW = $clog2(CNT_W + 1);

    logic [2:0]       state;
    logic             sync1, sync2, sync_d;
    logic             idx_p, match, run, watch, stall, div_done;
    logic [CNT_W-1:0] cnt, prev_period, cap, tol, delta, div_q, div_r;
    logic [CNT_W:0]   div_sh, div_diff;
    logic [DW-1:0]    div_cnt;
    logic [7:0]       match_cnt;
    logic             first_cap;

    assign idx_p    = sync2 & ~sync_d;
    assign cap      = cnt + 1'b1;
    assign tol      = prev_period >> TOL_SHIFT;
    assign delta    = cap >= prev_period ? cap - prev_period : prev_period - cap;
    assign match    = delta <= tol;
    assign watch    = state == S_ARM || state == S_MEAS || state == S_LOCK;
    assign run      = watch || state == S_DIV;
`ifdef SCAN_WATCHDOG_EN
    assign stall    = watch && (cnt == CNT_MAX || (cnt == CNT_W'(TIMEOUT) && !idx_p));
`else
    assign stall    = watch && cnt == CNT_MAX;
`endif
    assign div_sh   = {div_r, div_q[CNT_W-1]};
    assign div_diff = div_sh - (CNT_W + 1)'(resolution);
    assign div_done = div_cnt == DW'(CNT_W);

    assign sample_en = state == S_LOCK;
    assign locked    = sample_en;
    assign fault     = state == S_FAULT;
    assign busy      = state != S_IDLE && state != S_FAULT;

    // two-flop synchronizer followed by an edge register for the index pin
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) {sync1, sync2, sync_d} <= '0;
        else        {sync1, sync2, sync_d} <= {index_in, sync1, sync2};
    end

    // revolution period counter, restarted by each index and held clear when idle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                cnt <= '0;
        else if (!run || idx_p)    cnt <= '0;
        else if (cnt != CNT_MAX)   cnt <= cnt + 1'b1;
    end

    // sequencing: arm, measure until stable, divide, then track lock
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            resolution  <= '0;
            time_set    <= '0;
            period      <= '0;
            prev_period <= '0;
            match_cnt   <= '0;
            first_cap   <= 1'b0;
            div_q       <= '0;
            div_r       <= '0;
            div_cnt     <= '0;
        end else if (state != S_IDLE && !start_req) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start_req && res_cfg != '0) begin
                    resolution <= res_cfg;
                    state      <= S_ARM;
                end
                S_ARM: if (stall) state <= S_FAULT;
                else if (idx_p) begin
                    state     <= S_MEAS;
                    match_cnt <= '0;
                    first_cap <= 1'b1;
                end
                S_MEAS: if (stall) state <= S_FAULT;
                else if (idx_p) begin
                    period      <= cap;
                    prev_period <= cap;
                    first_cap   <= 1'b0;
                    match_cnt   <= !first_cap && match ? match_cnt + 8'd1 : 8'd0;
                    if (!first_cap && match && match_cnt + 8'd1 == 8'(LOCK_REVS)) begin
                        state   <= S_DIV;
                        div_q   <= cap;
                        div_r   <= '0;
                        div_cnt <= '0;
                    end
                end
                S_DIV: begin
                    if (idx_p) begin
                        period      <= cap;
                        prev_period <= cap;
                    end
                    if (div_done) begin
                        state <= div_q < CNT_W'(2) ? S_FAULT : S_LOCK;
                        if (div_q >= CNT_W'(2)) time_set <= div_q;
                    end else begin
                        div_r   <= div_diff[CNT_W] ? div_sh[CNT_W-1:0] : div_diff[CNT_W-1:0];
                        div_q   <= {div_q[CNT_W-2:0], ~div_diff[CNT_W]};
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_LOCK: if (stall) state <= S_FAULT;
                else if (idx_p) begin
                    period      <= cap;
                    prev_period <= cap;
                    if (!match) begin
                        state     <= S_MEAS;
                        match_cnt <= '0;
                        first_cap <= 1'b0;
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
